// File: rtl/ecc_pkg.sv
// Shared constants and FSM state type for the ECC signature serializer.
// Default geometry: 256-bit r/s split into 32-bit words, 16 words per signature.
package ecc_pkg;
    localparam int KEY_W  = 256;
    localparam int WORD_W = 32;
    localparam int WORDS  = 2 * KEY_W / WORD_W;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;
endpackage

// File: rtl/ecc_sig_shifter.sv
// Load/shift register holding one {r,s} signature, presented MSW first.
// Load takes priority over advance; word_cnt restarts at 0 on every load.
module ecc_sig_shifter
    import ecc_pkg::*;
#(
    parameter int KEY_W  = ecc_pkg::KEY_W,
    parameter int WORD_W = ecc_pkg::WORD_W
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                load_i,
    input  logic [2*KEY_W-1:0]  load_dat_i,
    input  logic                adv_i,
    output logic [WORD_W-1:0]   word_o,
    output logic                last_o
);
    localparam int NWORDS = 2 * KEY_W / WORD_W;
    localparam int CNT_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

    logic [2*KEY_W-1:0] sh_q, sh_d;
    logic [CNT_W-1:0]   word_cnt_q, word_cnt_d;

    always_comb begin
        sh_d       = sh_q;
        word_cnt_d = word_cnt_q;
        if (load_i) begin
            sh_d       = load_dat_i;
            word_cnt_d = '0;
        end else if (adv_i) begin
            sh_d       = sh_q << WORD_W;
            word_cnt_d = word_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sh_q       <= '0;
            word_cnt_q <= '0;
        end else begin
            sh_q       <= sh_d;
            word_cnt_q <= word_cnt_d;
        end
    end

    assign word_o = sh_q[2*KEY_W-1 -: WORD_W];
    assign last_o = (word_cnt_q == CNT_W'(NWORDS - 1));
endmodule

// File: rtl/ecc_sig_serializer.sv
// Captures (r,s) on sig_valid and streams 32-bit words over valid/ready, one word per cycle.
// Shifter plus one pending slot; a capture arriving with both full is dropped and counted.
module ecc_sig_serializer
    import ecc_pkg::*;
#(
    parameter int KEY_W  = ecc_pkg::KEY_W,
    parameter int WORD_W = ecc_pkg::WORD_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [KEY_W-1:0]   r,
    input  logic [KEY_W-1:0]   s,
    input  logic               sig_valid,
    input  logic               sig_fail,
    output logic [WORD_W-1:0]  dout,
    output logic               dout_valid,
    input  logic               dout_ready,
    output logic               dout_last,
    output logic               busy,
    output logic               fail_pulse,
    output logic               drop_pulse,
    output logic [7:0]         drop_cnt
);
    ser_state_e          state_q, state_d;
    logic [2*KEY_W-1:0]  pend_q, pend_d;
    logic                pend_vld_q, pend_vld_d;
    logic [7:0]          drop_cnt_q, drop_cnt_d;
    logic                drop_pulse_q, fail_pulse_q;

    logic                load;
    logic [2*KEY_W-1:0]  load_dat;
    logic                drop;
    logic [WORD_W-1:0]   sh_word;
    logic                sh_last;
    logic                xfer, last_xfer, cap;
    logic [2*KEY_W-1:0]  sig_dat;

    assign sig_dat   = {r, s};
    assign cap       = sig_valid && !sig_fail;
    assign xfer      = dout_valid && dout_ready;
    assign last_xfer = xfer && sh_last;

    always_comb begin
        state_d    = state_q;
        pend_d     = pend_q;
        pend_vld_d = pend_vld_q;
        load       = 1'b0;
        load_dat   = pend_q;
        drop       = 1'b0;
        case (state_q)
            IDLE: begin
                // A pending entry here is the bubble case: it left no room to load on the final transfer.
                if (pend_vld_q) begin
                    load       = 1'b1;
                    load_dat   = pend_q;
                    state_d    = SEND;
                    pend_vld_d = cap;
                    if (cap) pend_d = sig_dat;
                end else if (cap) begin
                    load     = 1'b1;
                    load_dat = sig_dat;
                    state_d  = SEND;
                end
            end
            SEND: begin
                if (last_xfer) begin
                    if (pend_vld_q) begin
                        load     = 1'b1;
                        load_dat = pend_q;
                    end else begin
                        state_d = IDLE;
                    end
                    pend_vld_d = cap;
                    if (cap) pend_d = sig_dat;
                end else if (cap) begin
                    if (!pend_vld_q) begin
                        pend_vld_d = 1'b1;
                        pend_d     = sig_dat;
                    end else begin
                        drop = 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign drop_cnt_d = (drop && drop_cnt_q != 8'hFF) ? drop_cnt_q + 8'd1 : drop_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            pend_q       <= '0;
            pend_vld_q   <= 1'b0;
            drop_cnt_q   <= '0;
            drop_pulse_q <= 1'b0;
            fail_pulse_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_q       <= pend_d;
            pend_vld_q   <= pend_vld_d;
            drop_cnt_q   <= drop_cnt_d;
            drop_pulse_q <= drop;
            fail_pulse_q <= sig_valid && sig_fail;
        end
    end

    ecc_sig_shifter #(
        .KEY_W  (KEY_W),
        .WORD_W (WORD_W)
    ) u_shifter (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_i     (load),
        .load_dat_i (load_dat),
        .adv_i      (xfer),
        .word_o     (sh_word),
        .last_o     (sh_last)
    );

    assign dout_valid = (state_q == SEND);
    assign dout       = dout_valid ? sh_word : '0;
    assign dout_last  = dout_valid && sh_last;
    assign busy       = (state_q == SEND) || pend_vld_q;
    assign fail_pulse = fail_pulse_q;
    assign drop_pulse = drop_pulse_q;
    assign drop_cnt   = drop_cnt_q;
endmodule

// File: tb/tb_ecc_sig_serializer.sv
// Scoreboard bench: expected words queued at capture, compared as the sink accepts them.
module tb_ecc_sig_serializer;
    localparam int KW = 256;
    localparam int WW = 32;
    localparam int NW = 2 * KW / WW;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [KW-1:0] r, s;
    logic          sig_valid, sig_fail;
    logic [WW-1:0] dout;
    logic          dout_valid, dout_ready, dout_last;
    logic          busy, fail_pulse, drop_pulse;
    logic [7:0]    drop_cnt;

    ecc_sig_serializer dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .r          (r),
        .s          (s),
        .sig_valid  (sig_valid),
        .sig_fail   (sig_fail),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_last  (dout_last),
        .busy       (busy),
        .fail_pulse (fail_pulse),
        .drop_pulse (drop_pulse),
        .drop_cnt   (drop_cnt)
    );

    always #5 clk = ~clk;

    int          total = 0;
    int          bad   = 0;
    logic [63:0] exp_q[$];
    int          cyc = 0;
    int          xfer_cnt = 0;
    int          first_cyc = -1;
    int          last_cyc  = -1;
    int          drop_seen = 0;
    logic        stall = 1'b0;
    logic [63:0] held = '0;

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h (cycle %0d)", tag, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (!rst_n) begin
            stall = 1'b0;
        end else begin
            if (stall && dout_valid)
                chk("hold", {31'b0, dout_last, dout}, held);
            if (!dout_valid)
                chk("idle_zero", {31'b0, dout_last, dout}, 64'd0);
            if (dout_valid && dout_ready) begin
                if (exp_q.size() == 0) chk("extra_word", 64'd1, 64'd0);
                else chk("word", {31'b0, dout_last, dout}, exp_q.pop_front());
                xfer_cnt++;
                if (first_cyc < 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            if (drop_pulse) drop_seen++;
            stall = dout_valid && !dout_ready;
            held  = {31'b0, dout_last, dout};
        end
    end

    task automatic push_sig(input logic [KW-1:0] rr, input logic [KW-1:0] ss);
        logic [WW-1:0] w;
        for (int i = 0; i < NW; i++) begin
            if (i < NW / 2) w = rr[KW-1-WW*i -: WW];
            else            w = ss[KW-1-WW*(i-NW/2) -: WW];
            exp_q.push_back({31'b0, (i == NW - 1), w});
        end
    endtask

    task automatic send_sig(input logic [KW-1:0] rr, input logic [KW-1:0] ss,
                            input logic fail, input logic expect_drop);
        r = rr; s = ss; sig_fail = fail; sig_valid = 1'b1;
        if (!fail && !expect_drop) push_sig(rr, ss);
        @(posedge clk); #1;
        sig_valid = 1'b0; sig_fail = 1'b0;
        r = '0; s = '0;
    endtask

    function automatic logic [KW-1:0] rnd_key();
        logic [KW-1:0] k;
        for (int i = 0; i < KW / 32; i++) k[i*32 +: 32] = $urandom;
        return k;
    endfunction

    task automatic wait_drain(input string tag, input int budget);
        int n = 0;
        while ((exp_q.size() != 0 || busy) && n < budget) begin
            @(negedge clk); n++;
        end
        chk(tag, {63'b0, (n < budget)}, 64'd1);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        logic [KW-1:0] ra, sa, rb, sb, rc, sc;
        int n;
        rst_n = 1'b0; r = '0; s = '0; sig_valid = 1'b0; sig_fail = 1'b0; dout_ready = 1'b0;
        #1;
        chk("rst_valid", {63'b0, dout_valid}, 64'd0);
        chk("rst_outs", {29'b0, dout_last, busy, fail_pulse, drop_pulse, dout}, 64'd0);
        chk("rst_dropcnt", {56'b0, drop_cnt}, 64'd0);
        tick(3);
        rst_n = 1'b1;
        tick(2);

        // 1: fixed pattern, ready always high
        dout_ready = 1'b1;
        ra = {32{8'h01}}; sa = {32{8'hFE}};
        send_sig(ra, sa, 1'b0, 1'b0);
        chk("t1_valid", {63'b0, dout_valid}, 64'd1);
        chk("t1_word0", {32'b0, dout}, 64'h0101_0101);
        xfer_cnt = 0;
        wait_drain("t1_drain", 100);
        chk("t1_count", xfer_cnt, NW);
        tick(2);

        // 2: ready toggles every cycle; 16 words over 31 cycles
        ra = rnd_key(); sa = rnd_key();
        first_cyc = -1;
        dout_ready = 1'b1;
        send_sig(ra, sa, 1'b0, 1'b0);
        n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(posedge clk); #1; dout_ready = ~dout_ready; n++;
        end
        chk("t2_timeout", {63'b0, (n < 200)}, 64'd1);
        chk("t2_span", last_cyc - first_cyc, 30);
        dout_ready = 1'b1;
        wait_drain("t2_drain", 50);
        tick(2);

        // 3: two signatures 3 cycles apart stream back to back
        ra = rnd_key(); sa = rnd_key(); rb = rnd_key(); sb = rnd_key();
        first_cyc = -1;
        send_sig(ra, sa, 1'b0, 1'b0);
        tick(2);
        send_sig(rb, sb, 1'b0, 1'b0);
        wait_drain("t3_drain", 200);
        chk("t3_span", last_cyc - first_cyc, 2 * NW - 1);
        tick(2);

        // 4: three captures with sink stalled -> third is dropped
        dout_ready = 1'b0;
        drop_seen = 0;
        ra = rnd_key(); sa = rnd_key(); rb = rnd_key(); sb = rnd_key(); rc = rnd_key(); sc = rnd_key();
        send_sig(ra, sa, 1'b0, 1'b0);
        tick(2);
        send_sig(rb, sb, 1'b0, 1'b0);
        chk("t4_busy", {63'b0, busy}, 64'd1);
        tick(3);
        send_sig(rc, sc, 1'b0, 1'b1);
        chk("t4_drop_pulse", {63'b0, drop_pulse}, 64'd1);
        chk("t4_drop_cnt", {56'b0, drop_cnt}, 64'd1);
        tick(5);
        dout_ready = 1'b1;
        wait_drain("t4_drain", 200);
        chk("t4_drop_seen", drop_seen, 1);
        tick(2);

        // 5: failed signature produces only a fail pulse
        ra = rnd_key(); sa = rnd_key();
        send_sig(ra, sa, 1'b1, 1'b0);
        chk("t5_fail_pulse", {63'b0, fail_pulse}, 64'd1);
        chk("t5_busy", {63'b0, busy}, 64'd0);
        chk("t5_valid", {63'b0, dout_valid}, 64'd0);
        tick(1);
        chk("t5_fail_clear", {63'b0, fail_pulse}, 64'd0);
        chk("t5_valid2", {63'b0, dout_valid}, 64'd0);
        chk("t5_drop_cnt", {56'b0, drop_cnt}, 64'd1);

        // 6: reset in the middle of a signature
        ra = rnd_key(); sa = rnd_key();
        xfer_cnt = 0;
        send_sig(ra, sa, 1'b0, 1'b0);
        n = 0;
        while (xfer_cnt < 5 && n < 50) begin
            @(posedge clk); n++;
        end
        chk("t6_reach", {63'b0, (n < 50)}, 64'd1);
        #2;
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t6_valid_async", {63'b0, dout_valid}, 64'd0);
        chk("t6_busy", {63'b0, busy}, 64'd0);
        chk("t6_drop_cnt", {56'b0, drop_cnt}, 64'd0);
        tick(2);
        rst_n = 1'b1;
        tick(2);
        chk("t6_quiet", {63'b0, dout_valid}, 64'd0);
        rb = rnd_key(); sb = rnd_key();
        send_sig(rb, sb, 1'b0, 1'b0);
        chk("t6_msw", {32'b0, dout}, {32'b0, rb[KW-1 -: WW]});
        wait_drain("t6_drain", 100);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
